// File: rtl/paralelo_serial_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter and its
// serial-to-parallel receiver counterpart.
package paralelo_serial_pkg;

   typedef enum logic {
      VACIO,
      TRANSMITIENDO
   } estado_t;

   // Bit 0 is the first bit on the line: 0,0,1,1,1,1,1,0,1,0.
   localparam logic [9:0] K28_5 = 10'h17C;

   localparam int ANCHO_DEF = 10;

endpackage

// File: rtl/paralelo_serial_contador.sv
// contador_bits: modulo-N bit counter with enable, asynchronous active-low reset
// and a last-bit flag; also exposes its next value for registered outputs.
module contador_bits
   import paralelo_serial_pkg::*;
#(
   parameter int N = ANCHO_DEF,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         reset_L,
   input  logic         en,
   output logic [W-1:0] cuenta,
   output logic [W-1:0] siguiente,
   output logic         fin
);

   assign fin = (cuenta == W'(N - 1));

   always_comb begin
      siguiente = cuenta;
      if (en) begin
         siguiente = fin ? '0 : cuenta + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         cuenta <= '0;
      end else begin
         cuenta <= siguiente;
      end
   end

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter, LSB first, with a one-word holding buffer.
// Define PARALELO_SERIAL_IDLE_EN to send K28.5 commas instead of idling low.
module paralelo_serial
   import paralelo_serial_pkg::*;
#(
   parameter int cantidadBits = ANCHO_DEF
) (
   input  logic                    clk,
   input  logic                    reset_L,
   input  logic [cantidadBits-1:0] entradas,
   input  logic                    valido,
   output logic                    listo,
   output logic                    salida,
   output logic                    inicio,
   output logic                    activo
);

   localparam int CW = (cantidadBits > 1) ? $clog2(cantidadBits) : 1;

`ifdef PARALELO_SERIAL_IDLE_EN
   if (cantidadBits != 10) begin : g_ancho_invalido
      $error("paralelo_serial: idle comma mode requires cantidadBits == 10");
   end
`endif

   estado_t                 estado, estado_sig;
   logic [cantidadBits-1:0] desplaz, desplaz_sig;
   logic [cantidadBits-1:0] reten, reten_sig;
   logic                    lleno, lleno_sig;
   logic                    dato, dato_sig;
   logic [CW-1:0]           cuenta, cuenta_sig;
   logic                    fin;
   logic                    acepta;
   logic                    salida_sig, inicio_sig, activo_sig;

   assign listo  = !lleno;
   assign acepta = valido && listo;

   contador_bits #(
      .N (cantidadBits),
      .W (CW)
   ) u_contador (
      .clk       (clk),
      .reset_L   (reset_L),
      .en        (estado == TRANSMITIENDO),
      .cuenta    (cuenta),
      .siguiente (cuenta_sig),
      .fin       (fin)
   );

   always_comb begin
      estado_sig  = estado;
      desplaz_sig = desplaz;
      reten_sig   = reten;
      lleno_sig   = lleno;
      dato_sig    = dato;
      unique case (estado)
         VACIO: begin
`ifdef PARALELO_SERIAL_IDLE_EN
            // Only reached right after reset: start the comma stream at once.
            estado_sig = TRANSMITIENDO;
            if (acepta) begin
               desplaz_sig = entradas;
               dato_sig    = 1'b1;
            end else begin
               desplaz_sig = K28_5;
               dato_sig    = 1'b0;
            end
`else
            if (acepta) begin
               desplaz_sig = entradas;
               dato_sig    = 1'b1;
               estado_sig  = TRANSMITIENDO;
            end
`endif
         end
         TRANSMITIENDO: begin
            if (fin) begin
               // Word boundary: held word first, then same-edge bypass, then idle.
               if (lleno) begin
                  desplaz_sig = reten;
                  dato_sig    = 1'b1;
                  lleno_sig   = acepta;
                  if (acepta) begin
                     reten_sig = entradas;
                  end
               end else if (acepta) begin
                  desplaz_sig = entradas;
                  dato_sig    = 1'b1;
               end else begin
`ifdef PARALELO_SERIAL_IDLE_EN
                  desplaz_sig = K28_5;
                  dato_sig    = 1'b0;
`else
                  estado_sig  = VACIO;
                  dato_sig    = 1'b0;
`endif
               end
            end else if (acepta) begin
               reten_sig = entradas;
               lleno_sig = 1'b1;
            end
         end
         default: estado_sig = VACIO;
      endcase
   end

   // Outputs are registered from next-state so they line up with the bit on the wire.
   assign salida_sig = (estado_sig == TRANSMITIENDO) ? desplaz_sig[cuenta_sig] : 1'b0;
   assign inicio_sig = (estado_sig == TRANSMITIENDO) && (cuenta_sig == '0);
   assign activo_sig = (estado_sig == TRANSMITIENDO) && dato_sig;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         estado <= VACIO;
         lleno  <= 1'b0;
         dato   <= 1'b0;
         salida <= 1'b0;
         inicio <= 1'b0;
         activo <= 1'b0;
      end else begin
         estado <= estado_sig;
         lleno  <= lleno_sig;
         dato   <= dato_sig;
         salida <= salida_sig;
         inicio <= inicio_sig;
         activo <= activo_sig;
      end
   end

   always_ff @(posedge clk) begin
      desplaz <= desplaz_sig;
      reten   <= reten_sig;
   end

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed and loopback bench for paralelo_serial in its default (no comma) build.
module tb_paralelo_serial;

   logic       clk;
   logic       reset_L;
   logic [9:0] entradas;
   logic       valido;
   logic       listo;
   logic       salida;
   logic       inicio;
   logic       activo;

   int total;
   int pasadas;

   paralelo_serial #(
      .cantidadBits (10)
   ) dut (
      .clk      (clk),
      .reset_L  (reset_L),
      .entradas (entradas),
      .valido   (valido),
      .listo    (listo),
      .salida   (salida),
      .inicio   (inicio),
      .activo   (activo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] palabra;
      string      bits;
   } vector_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic string b2s(input logic b);
      return b ? "1" : "0";
   endfunction

   task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) pasadas++;
      else $display("FAIL %s: got %0h expected %0h", nombre, got, exp);
   endtask

   task automatic chks(input string nombre, input string got, input string exp);
      total++;
      if (got == exp) pasadas++;
      else $display("FAIL %s: got %s expected %s", nombre, got, exp);
   endtask

   initial begin
      vector_t    tabla[6];
      string      s_sal, s_ini, s_act, s_lis;
      logic [9:0] palabras[3];
      int         idx;
      logic       acc;
      int         unos;
      logic [9:0] cola[$];
      logic [9:0] w_acc, rx_w, esperado;
      int         rx_k, n_env, n_rx;

      total    = 0;
      pasadas  = 0;
      reset_L  = 1'b0;
      valido   = 1'b0;
      entradas = '0;

      tabla[0] = '{10'h2A5, "1010010101"};
      tabla[1] = '{10'h001, "1000000000"};
      tabla[2] = '{10'h200, "0000000001"};
      tabla[3] = '{10'h17C, "0011111010"};
      tabla[4] = '{10'h0F0, "0000111100"};
      tabla[5] = '{10'h3FF, "1111111111"};

      tick();
      tick();
      chk("reset_salida", 32'(salida), 32'd0);
      chk("reset_inicio", 32'(inicio), 32'd0);
      chk("reset_activo", 32'(activo), 32'd0);
      chk("reset_listo",  32'(listo),  32'd1);
      reset_L = 1'b1;
      tick();

      // Single words, each followed by return to idle
      for (int i = 0; i < 6; i++) begin
         entradas = tabla[i].palabra;
         valido   = 1'b1;
         tick();
         valido = 1'b0;
         s_sal = ""; s_ini = ""; s_act = ""; s_lis = "";
         for (int k = 0; k < 10; k++) begin
            s_sal = {s_sal, b2s(salida)};
            s_ini = {s_ini, b2s(inicio)};
            s_act = {s_act, b2s(activo)};
            s_lis = {s_lis, b2s(listo)};
            tick();
         end
         chks($sformatf("word%0d_bits", i), s_sal, tabla[i].bits);
         chks($sformatf("word%0d_inicio", i), s_ini, "1000000000");
         chks($sformatf("word%0d_activo", i), s_act, "1111111111");
         chks($sformatf("word%0d_listo", i), s_lis, "1111111111");
         chk($sformatf("word%0d_idle", i), 32'({salida, inicio, activo}), 32'd0);
      end

      // Back-to-back stream through the holding register
      palabras[0] = 10'h3FF;
      palabras[1] = 10'h000;
      palabras[2] = 10'h155;
      idx = 0;
      entradas = palabras[0];
      valido   = 1'b1;
      s_sal = ""; s_ini = ""; s_lis = "";
      for (int c = -1; c < 30; c++) begin
         if (c >= 0) begin
            s_sal = {s_sal, b2s(salida)};
            s_ini = {s_ini, b2s(inicio)};
            s_lis = {s_lis, b2s(listo)};
         end
         acc = valido && listo;
         tick();
         if (acc) begin
            idx++;
            if (idx < 3) entradas = palabras[idx];
            else valido = 1'b0;
         end
      end
      chks("b2b_bits", s_sal, "111111111100000000001010101010");
      chks("b2b_inicio", s_ini, "100000000010000000001000000000");
      chks("b2b_listo", s_lis, "100000000010000000001111111111");
      chk("b2b_idle", 32'({salida, activo}), 32'd0);

      // Word presented exactly on the last-bit edge goes straight to the shifter
      entradas = 10'h0F0;
      valido   = 1'b1;
      tick();
      valido = 1'b0;
      s_sal = ""; s_ini = ""; s_lis = "";
      for (int c = 0; c < 20; c++) begin
         s_sal = {s_sal, b2s(salida)};
         s_ini = {s_ini, b2s(inicio)};
         s_lis = {s_lis, b2s(listo)};
         if (c == 9) begin
            entradas = 10'h2A5;
            valido   = 1'b1;
         end
         tick();
         valido = 1'b0;
      end
      chks("bypass_bits", s_sal, "00001111001010010101");
      chks("bypass_inicio", s_ini, "10000000001000000000");
      chks("bypass_listo", s_lis, "11111111111111111111");
      chk("bypass_idle", 32'({salida, activo}), 32'd0);

      // Reset at bit 4 with a second word held
      entradas = 10'h3FF;
      valido   = 1'b1;
      tick();
      tick();
      valido = 1'b0;
      chk("rst_mid_lleno", 32'(listo), 32'd0);
      tick();
      tick();
      tick();
      chk("rst_mid_before", 32'({salida, activo}), 32'b11);
      #2;
      reset_L = 1'b0;
      #1;
      chk("rst_mid_outputs", 32'({salida, inicio, activo}), 32'd0);
      chk("rst_mid_listo", 32'(listo), 32'd1);
      tick();
      reset_L = 1'b1;
      unos = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (salida || inicio || activo || !listo) unos++;
      end
      chk("rst_mid_no_remnant", 32'(unos), 32'd0);

      // Loopback against a bench-side deserializer
      n_env = 0;
      n_rx  = 0;
      rx_k  = 0;
      rx_w  = '0;
      valido   = 1'b1;
      entradas = 10'($urandom);
      for (int c = 0; c < 20000 && n_rx < 200; c++) begin
         acc   = valido && listo;
         w_acc = entradas;
         tick();
         if (acc) begin
            cola.push_back(w_acc);
            n_env++;
         end
         if (activo) begin
            if (inicio) rx_k = 0;
            rx_w[rx_k] = salida;
            rx_k++;
            if (rx_k == 10) begin
               esperado = (cola.size() > 0) ? cola.pop_front() : ~rx_w;
               chk("loopback_word", 32'(rx_w), 32'(esperado));
               n_rx++;
               rx_k = 0;
            end
         end
         if (n_env < 200) begin
            valido   = ($urandom_range(0, 3) != 0);
            entradas = 10'($urandom);
         end else begin
            valido = 1'b0;
         end
      end
      chk("loopback_count", 32'(n_rx), 32'd200);

      $display("%0d/%0d checks passed", pasadas, total);
      $finish;
   end

endmodule
